// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response handshake bundle for mem_access_ctrl.
// master = pipeline (issues requests, takes responses), slave = controller.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller: IDLE -> ACCESS (one strobe cycle) -> RESP.
// Optional out-of-range fault reporting enabled by defining MEM_BOUNDS_CHECK_EN.
module mem_access_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [15:0]       txn_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   fault_q;
  logic   addr_oob;
  logic   req_fault;

  assign addr_oob = (64'(bus.req_addr) >= 64'(MEM_DEPTH));

`ifdef MEM_BOUNDS_CHECK_EN
  assign req_fault = addr_oob;
`else
  // Bounds checking disabled: fault is constant 0, addr_oob only keeps MEM_DEPTH referenced.
  assign req_fault = 1'b0 & addr_oob;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      fault_q        <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.rsp_fault  <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_write_en   <= 1'b0;
      mem_read_en    <= 1'b0;
      txn_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state          <= ACCESS;
            bus.req_ready  <= 1'b0;
            fault_q        <= req_fault;
            mem_addr       <= bus.req_addr;
            mem_write_data <= (bus.req_we && !req_fault) ? bus.req_wdata : '0;
            mem_write_en   <= bus.req_we && !req_fault;
            mem_read_en    <= !bus.req_we && !req_fault;
          end
        end
        ACCESS: begin
          state          <= RESP;
          bus.rsp_valid  <= 1'b1;
          bus.rsp_rdata  <= mem_read_en ? mem_read_data : '0;
          bus.rsp_fault  <= fault_q;
          mem_addr       <= '0;
          mem_write_data <= '0;
          mem_write_en   <= 1'b0;
          mem_read_en    <= 1'b0;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            txn_count     <= txn_count + 16'd1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
          mem_write_en  <= 1'b0;
          mem_read_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; behavioural memory with combinational read.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en;
  logic              mem_read_en;
  logic [DATA_W-1:0] mem_read_data;
  logic [15:0]       txn_count;
  logic [DATA_W-1:0] mem [0:511];

  int checks;
  int failures;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(256)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_en    (mem_read_en),
    .mem_read_data  (mem_read_data),
    .txn_count      (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write_en) mem[mem_addr[8:0]] <= mem_write_data;
  assign mem_read_data = mem[mem_addr[8:0]];

  // Present a request at a negedge; returns at the negedge of the ACCESS cycle.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 16'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", bus.rsp_rdata); end
    checks++; if (bus.rsp_fault !== 1'b0) begin failures++; $display("FAIL reset_rsp_fault got=%b exp=0", bus.rsp_fault); end
    checks++; if ({mem_write_en, mem_read_en} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {mem_write_en, mem_read_en}); end
    checks++; if ({mem_addr, mem_write_data} !== 32'h0) begin failures++; $display("FAIL reset_mem_bus got=%h exp=0", {mem_addr, mem_write_data}); end
    checks++; if (txn_count !== 16'h0) begin failures++; $display("FAIL reset_txn_count got=%h exp=0", txn_count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store;
    bus.rsp_ready = 1'b1;
    issue(1'b1, 16'd5, 16'hA5A5);
    checks++; if ({mem_write_en, mem_read_en} !== 2'b10) begin failures++; $display("FAIL store_strobes got=%b exp=10", {mem_write_en, mem_read_en}); end
    checks++; if (mem_addr !== 16'd5) begin failures++; $display("FAIL store_mem_addr got=%h exp=0005", mem_addr); end
    checks++; if (mem_write_data !== 16'hA5A5) begin failures++; $display("FAIL store_mem_wdata got=%h exp=a5a5", mem_write_data); end
    checks++; if ({bus.req_ready, bus.rsp_valid} !== 2'b00) begin failures++; $display("FAIL store_access_hs got=%b exp=00", {bus.req_ready, bus.rsp_valid}); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL store_rsp_valid got=%b exp=1", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 16'h0) begin failures++; $display("FAIL store_rsp_rdata got=%h exp=0", bus.rsp_rdata); end
    checks++; if ({mem_write_en, mem_read_en, mem_addr} !== 18'h0) begin failures++; $display("FAIL store_resp_quiet got=%h exp=0", {mem_write_en, mem_read_en, mem_addr}); end
    @(negedge clk);
    checks++; if (txn_count !== 16'd1) begin failures++; $display("FAIL store_txn_count got=%0d exp=1", txn_count); end
    checks++; if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin failures++; $display("FAIL store_back_idle got=%b exp=10", {bus.req_ready, bus.rsp_valid}); end
  endtask

  task automatic test_load;
    issue(1'b0, 16'd5, 16'h0);
    checks++; if ({mem_write_en, mem_read_en} !== 2'b01) begin failures++; $display("FAIL load_strobes got=%b exp=01", {mem_write_en, mem_read_en}); end
    checks++; if (mem_addr !== 16'd5) begin failures++; $display("FAIL load_mem_addr got=%h exp=0005", mem_addr); end
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 16'hA5A5}) begin failures++; $display("FAIL load_rsp got=%b/%h exp=1/a5a5", bus.rsp_valid, bus.rsp_rdata); end
    @(negedge clk);
    checks++; if (txn_count !== 16'd2) begin failures++; $display("FAIL load_txn_count got=%0d exp=2", txn_count); end
  endtask

  task automatic test_stall;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 16'd5, 16'h0);
    checks++; if (mem_read_en !== 1'b1) begin failures++; $display("FAIL stall_read_en got=%b exp=1", mem_read_en); end
    // A competing request during the stall must not be taken.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'd9; bus.req_wdata = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.req_ready, mem_write_en, mem_read_en, txn_count} !==
          {1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'd2}) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got v=%b d=%h rdy=%b we=%b re=%b n=%0d exp v=1 d=a5a5 rdy=0 we=0 re=0 n=2",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, mem_write_en, mem_read_en, txn_count);
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin failures++; $display("FAIL stall_release got=%b exp=01", {bus.rsp_valid, bus.req_ready}); end
    checks++; if (txn_count !== 16'd3) begin failures++; $display("FAIL stall_txn_count got=%0d exp=3", txn_count); end
    @(negedge clk);
    checks++; if (mem_write_en !== 1'b0) begin failures++; $display("FAIL stall_no_lost_write got=%b exp=0", mem_write_en); end
  endtask

  task automatic test_back_to_back;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'd10; bus.req_wdata = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_addr = 16'd10; bus.req_wdata = 16'h0;
    checks++; if ({mem_write_en, mem_addr} !== {1'b1, 16'd10}) begin failures++; $display("FAIL b2b_store_access got=%b/%h exp=1/000a", mem_write_en, mem_addr); end
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.req_ready, mem_read_en} !== 3'b100) begin failures++; $display("FAIL b2b_resp got=%b exp=100", {bus.rsp_valid, bus.req_ready, mem_read_en}); end
    @(negedge clk);
    checks++; if ({bus.req_ready, txn_count} !== {1'b1, 16'd4}) begin failures++; $display("FAIL b2b_idle got=%b/%0d exp=1/4", bus.req_ready, txn_count); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++; if ({mem_read_en, mem_addr} !== {1'b1, 16'd10}) begin failures++; $display("FAIL b2b_load_access got=%b/%h exp=1/000a", mem_read_en, mem_addr); end
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 16'h1234}) begin failures++; $display("FAIL b2b_load_rsp got=%b/%h exp=1/1234", bus.rsp_valid, bus.rsp_rdata); end
    @(negedge clk);
    checks++; if (txn_count !== 16'd5) begin failures++; $display("FAIL b2b_txn_count got=%0d exp=5", txn_count); end
  endtask

  task automatic test_bounds;
    issue(1'b0, 16'd300, 16'h0);
`ifdef MEM_BOUNDS_CHECK_EN
    checks++; if ({mem_write_en, mem_read_en} !== 2'b00) begin failures++; $display("FAIL bounds_strobes got=%b exp=00", {mem_write_en, mem_read_en}); end
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_fault, bus.rsp_rdata} !== {2'b11, 16'h0}) begin failures++; $display("FAIL bounds_rsp got=%b/%b/%h exp=1/1/0000", bus.rsp_valid, bus.rsp_fault, bus.rsp_rdata); end
`else
    checks++; if ({mem_read_en, mem_addr} !== {1'b1, 16'd300}) begin failures++; $display("FAIL bounds_forward got=%b/%0d exp=1/300", mem_read_en, mem_addr); end
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_fault} !== 2'b10) begin failures++; $display("FAIL bounds_rsp got=%b/%b exp=1/0", bus.rsp_valid, bus.rsp_fault); end
`endif
    @(negedge clk);
    checks++; if ({txn_count, bus.rsp_fault} !== {16'd6, 1'b0} && txn_count !== 16'd6) begin failures++; $display("FAIL bounds_txn_count got=%0d exp=6", txn_count); end
  endtask

  task automatic test_reset_mid_access;
    issue(1'b1, 16'd7, 16'h5555);
    checks++; if (mem_write_en !== 1'b1) begin failures++; $display("FAIL rstmid_pre_we got=%b exp=1", mem_write_en); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({mem_write_en, mem_read_en} !== 2'b00) begin failures++; $display("FAIL rstmid_strobes got=%b exp=00", {mem_write_en, mem_read_en}); end
    checks++; if ({mem_addr, mem_write_data} !== 32'h0) begin failures++; $display("FAIL rstmid_mem_bus got=%h exp=0", {mem_addr, mem_write_data}); end
    checks++; if ({bus.rsp_valid, txn_count} !== 17'h0) begin failures++; $display("FAIL rstmid_rsp_cnt got=%b/%0d exp=0/0", bus.rsp_valid, txn_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin failures++; $display("FAIL rstmid_after got=%b exp=10", {bus.req_ready, bus.rsp_valid}); end
  endtask

  task automatic test_txn_wrap;
    force dut.txn_count = 16'hFFFF;
    #1 release dut.txn_count;
    @(negedge clk);
    issue(1'b0, 16'd5, 16'h0);
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 16'hA5A5}) begin failures++; $display("FAIL wrap_rsp got=%b/%h exp=1/a5a5", bus.rsp_valid, bus.rsp_rdata); end
    @(negedge clk);
    checks++; if (txn_count !== 16'h0) begin failures++; $display("FAIL wrap_txn_count got=%h exp=0000", txn_count); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_store();
    test_load();
    test_stall();
    test_back_to_back();
    test_bounds();
    test_reset_mid_access();
    test_txn_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
